// File: rtl/axi_dma_pkg.sv
// ============================================================================
// axi_dma_pkg : shared FSM encodings, AXI constants and helpers for the DMA
//               read engine.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package axi_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_DONE = 2'd3
    } rd_state_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // AXI beat size code: log2 of the bytes per beat.
    function automatic logic [2:0] calc_arsize(input int width_bits);
        return 3'($clog2(width_bits / 8));
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_rd_skid.sv
// ============================================================================
// axi_rd_skid : 2-entry fully registered valid/ready slice.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module axi_rd_skid #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;
    logic             push;
    logic             pop;

    // Ready depends only on the occupancy register, so upstream sees no
    // combinational path from the downstream ready.
    assign ready_o = (cnt_q != 2'd2);
    assign valid_o = (cnt_q != 2'd0);
    assign data_o  = mem_q[rd_ptr_q];
    assign push    = valid_i & ready_o;
    assign pop     = valid_o & ready_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_dma_rd_engine.sv
// ============================================================================
// axi_dma_rd_engine : AXI4 read master issuing one INCR burst per start pulse.
//                     Optional counters under AXI_DMA_RD_PERF_EN.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module axi_dma_rd_engine
    import axi_dma_pkg::*;
#(
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_DA = 32,
    parameter int AXI_WIDTH_ID = 4,
    parameter int BIT_TRANS    = 18,
    parameter int MAX_BURST    = 16,
    parameter int RD_ID        = 0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_ctrl_read,
    input  logic [AXI_WIDTH_AD-1:0] i_read_addr,
    input  logic [BIT_TRANS-1:0]    i_num_trans,
    output logic                    o_read_done,
    output logic                    o_busy,
    output logic                    o_err,
    output logic [AXI_WIDTH_ID-1:0] M_ARID,
    output logic [AXI_WIDTH_AD-1:0] M_ARADDR,
    output logic [7:0]              M_ARLEN,
    output logic [2:0]              M_ARSIZE,
    output logic [1:0]              M_ARBURST,
    output logic                    M_ARVALID,
    input  logic                    M_ARREADY,
    input  logic [AXI_WIDTH_ID-1:0] M_RID,
    input  logic [AXI_WIDTH_DA-1:0] M_RDATA,
    input  logic [1:0]              M_RRESP,
    input  logic                    M_RLAST,
    input  logic                    M_RVALID,
    output logic                    M_RREADY,
    output logic [AXI_WIDTH_DA-1:0] o_rd_data,
    output logic                    o_rd_valid,
    output logic                    o_rd_last,
    input  logic                    i_rd_ready
`ifdef AXI_DMA_RD_PERF_EN
    ,
    output logic [31:0]             o_perf_lat,
    output logic [31:0]             o_perf_stall
`endif
);

    localparam int CW = $clog2(MAX_BURST + 1);

    rd_state_t               state_q, state_d;
    logic [AXI_WIDTH_AD-1:0] addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    rxdone_q, rxdone_d;
    logic [CW-1:0]           eff_len;
    logic                    len_over;
    logic                    skid_ready;
    logic                    beat_acc;
    logic                    beat_final;
    logic                    out_last_hs;

    assign len_over = (i_num_trans > BIT_TRANS'(MAX_BURST));

    always_comb begin
        eff_len = i_num_trans[CW-1:0];
        if (i_num_trans == '0) begin
            eff_len = CW'(1);
        end else if (len_over) begin
            eff_len = CW'(MAX_BURST);
        end
    end

    // Once the burst's final beat is captured, stop accepting until drained.
    assign M_RREADY    = (state_q == ST_R) & skid_ready & ~rxdone_q;
    assign beat_acc    = M_RVALID & M_RREADY;
    assign beat_final  = M_RLAST | (cnt_q == CW'(1));
    assign out_last_hs = o_rd_valid & i_rd_ready & o_rd_last;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rxdone_d = rxdone_q;
        case (state_q)
            ST_IDLE: begin
                if (i_ctrl_read) begin
                    addr_d  = i_read_addr;
                    len_d   = 8'(eff_len - CW'(1));
                    cnt_d   = eff_len;
                    err_d   = len_over;
                    state_d = ST_AR;
                end
            end
            ST_AR: begin
                if (i_ctrl_read) begin
                    err_d = 1'b1;
                end
                if (M_ARREADY) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (i_ctrl_read) begin
                    err_d = 1'b1;
                end
                if (beat_acc) begin
                    cnt_d = cnt_q - CW'(1);
                    if ((M_RRESP != RESP_OKAY) || (M_RID != AXI_WIDTH_ID'(RD_ID))) begin
                        err_d = 1'b1;
                    end
                    // RLAST must coincide exactly with the expected final beat.
                    if (M_RLAST != (cnt_q == CW'(1))) begin
                        err_d = 1'b1;
                    end
                    if (beat_final) begin
                        rxdone_d = 1'b1;
                    end
                end
                if (out_last_hs) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                rxdone_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rxdone_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rxdone_q <= rxdone_d;
        end
    end

    assign M_ARID      = AXI_WIDTH_ID'(RD_ID);
    assign M_ARADDR    = addr_q;
    assign M_ARLEN     = len_q;
    assign M_ARSIZE    = calc_arsize(AXI_WIDTH_DA);
    assign M_ARBURST   = BURST_INCR;
    assign M_ARVALID   = (state_q == ST_AR);
    assign o_read_done = (state_q == ST_DONE);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_err       = err_q;

    axi_rd_skid #(
        .WIDTH (AXI_WIDTH_DA + 1)
    ) u_skid (
        .clk     (clk),
        .rstn    (rstn),
        .data_i  ({M_RDATA, beat_final}),
        .valid_i (beat_acc),
        .ready_o (skid_ready),
        .data_o  ({o_rd_data, o_rd_last}),
        .valid_o (o_rd_valid),
        .ready_i (i_rd_ready)
    );

`ifdef AXI_DMA_RD_PERF_EN
    logic [31:0] lat_cnt_q;
    logic [31:0] perf_lat_q;
    logic [31:0] stall_q;
    logic        lat_wait_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lat_cnt_q  <= '0;
            perf_lat_q <= '0;
            stall_q    <= '0;
            lat_wait_q <= 1'b0;
        end else begin
            if ((state_q == ST_AR) && M_ARREADY) begin
                lat_cnt_q  <= 32'd1;
                lat_wait_q <= 1'b1;
            end else if (lat_wait_q) begin
                if (beat_acc) begin
                    perf_lat_q <= lat_cnt_q;
                    lat_wait_q <= 1'b0;
                end else begin
                    lat_cnt_q <= lat_cnt_q + 32'd1;
                end
            end
            if (o_rd_valid && !i_rd_ready && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign o_perf_lat   = perf_lat_q;
    assign o_perf_stall = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_dma_rd_engine.sv
// ============================================================================
// tb_axi_dma_rd_engine : directed self-checking bench for axi_dma_rd_engine.
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_axi_dma_rd_engine;

    logic        clk;
    logic        rstn;
    logic        i_ctrl_read;
    logic [31:0] i_read_addr;
    logic [17:0] i_num_trans;
    logic        o_read_done;
    logic        o_busy;
    logic        o_err;
    logic [3:0]  M_ARID;
    logic [31:0] M_ARADDR;
    logic [7:0]  M_ARLEN;
    logic [2:0]  M_ARSIZE;
    logic [1:0]  M_ARBURST;
    logic        M_ARVALID;
    logic        M_ARREADY;
    logic [3:0]  M_RID;
    logic [31:0] M_RDATA;
    logic [1:0]  M_RRESP;
    logic        M_RLAST;
    logic        M_RVALID;
    logic        M_RREADY;
    logic [31:0] o_rd_data;
    logic        o_rd_valid;
    logic        o_rd_last;
    logic        i_rd_ready;
`ifdef AXI_DMA_RD_PERF_EN
    logic [31:0] o_perf_lat;
    logic [31:0] o_perf_stall;
`endif

    axi_dma_rd_engine dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_ctrl_read (i_ctrl_read),
        .i_read_addr (i_read_addr),
        .i_num_trans (i_num_trans),
        .o_read_done (o_read_done),
        .o_busy      (o_busy),
        .o_err       (o_err),
        .M_ARID      (M_ARID),
        .M_ARADDR    (M_ARADDR),
        .M_ARLEN     (M_ARLEN),
        .M_ARSIZE    (M_ARSIZE),
        .M_ARBURST   (M_ARBURST),
        .M_ARVALID   (M_ARVALID),
        .M_ARREADY   (M_ARREADY),
        .M_RID       (M_RID),
        .M_RDATA     (M_RDATA),
        .M_RRESP     (M_RRESP),
        .M_RLAST     (M_RLAST),
        .M_RVALID    (M_RVALID),
        .M_RREADY    (M_RREADY),
        .o_rd_data   (o_rd_data),
        .o_rd_valid  (o_rd_valid),
        .o_rd_last   (o_rd_last),
        .i_rd_ready  (i_rd_ready)
`ifdef AXI_DMA_RD_PERF_EN
        ,
        .o_perf_lat  (o_perf_lat),
        .o_perf_stall(o_perf_stall)
`endif
    );

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_hs_cyc = 0;
    int ar_cnt = 0;
    int stall_r = 0;
    int max_stall_r = 0;
    int rready_low_seen = 0;
    int r_waits = 0;
    logic [32:0] q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Downstream/AXI observer, sampled away from the active edge.
    always @(negedge clk) begin
        if (rstn) begin
            if (o_rd_valid && i_rd_ready) begin
                q.push_back({o_rd_last, o_rd_data});
                if (o_rd_last) last_hs_cyc = cyc;
            end
            if (o_read_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (M_ARVALID && M_ARREADY) ar_cnt++;
            if (!i_rd_ready) begin
                if (M_RVALID && M_RREADY) stall_r++;
                if (stall_r > max_stall_r) max_stall_r = stall_r;
                if (!M_RREADY) rready_low_seen = 1;
            end else begin
                stall_r = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [31:0] a, input logic [17:0] n);
        @(posedge clk); #1;
        done_cnt = 0;
        ar_cnt = 0;
        r_waits = 0;
        q.delete();
        i_ctrl_read = 1'b1;
        i_read_addr = a;
        i_num_trans = n;
        @(posedge clk); #1;
        i_ctrl_read = 1'b0;
    endtask

    // Holds ARREADY low for 'delay' cycles; counts cycles with a stable request.
    task automatic do_ar(input int delay, input logic [31:0] ea, input logic [7:0] el, output int hold);
        hold = 0;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            if (M_ARVALID && M_ARADDR == ea && M_ARLEN == el) hold++;
            @(posedge clk); #1;
        end
        M_ARREADY = 1'b1;
        @(negedge clk);
        if (M_ARVALID && M_ARADDR == ea && M_ARLEN == el) hold++;
        @(posedge clk); #1;
        M_ARREADY = 1'b0;
    endtask

    task automatic r_beat(input logic [31:0] d, input logic [1:0] resp, input logic last);
        int guard;
        guard = 0;
        M_RVALID = 1'b1;
        M_RDATA = d;
        M_RRESP = resp;
        M_RLAST = last;
        @(negedge clk);
        while (!M_RREADY && guard < 200) begin
            guard++;
            r_waits++;
            @(negedge clk);
        end
        if (guard >= 200) check("r_beat_timeout", 1, 0);
        @(posedge clk); #1;
        M_RVALID = 1'b0;
        M_RLAST = 1'b0;
        M_RRESP = 2'b00;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!o_busy) break;
        end
        check({tag, "_idle"}, (i < 60), 1);
    endtask

    task automatic check_beats(input string tag, input int n, input logic [31:0] base);
        int bad;
        bad = 0;
        check({tag, "_count"}, q.size(), n);
        for (int i = 0; i < q.size() && i < n; i++) begin
            if (q[i] !== {(i == n - 1), base + 32'(i)}) bad++;
        end
        check({tag, "_order"}, bad, 0);
    endtask

    initial begin
        int hold;
        rstn = 1'b0;
        i_ctrl_read = 1'b0;
        i_read_addr = '0;
        i_num_trans = '0;
        M_ARREADY = 1'b0;
        M_RID = '0;
        M_RDATA = '0;
        M_RRESP = '0;
        M_RLAST = 1'b0;
        M_RVALID = 1'b0;
        i_rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_arsize", M_ARSIZE, 3'd2);
        check("rst_arburst", M_ARBURST, 2'b01);
        check("rst_arvalid", M_ARVALID, 0);
        check("rst_rready", M_RREADY, 0);
        check("rst_busy", o_busy, 0);
        check("rst_err", o_err, 0);
        check("rst_rd_valid", o_rd_valid, 0);
        check("rst_done", o_read_done, 0);
        check("rst_araddr", M_ARADDR, 0);
        check("rst_arlen", M_ARLEN, 0);

        // Basic 16-beat burst, no backpressure
        start(32'h1000_0040, 18'd16);
        check("t1_busy", o_busy, 1);
        do_ar(0, 32'h1000_0040, 8'd15, hold);
        check("t1_ar_hold", hold, 1);
        for (int i = 0; i < 16; i++) r_beat(32'hA000_0000 + 32'(i), 2'b00, (i == 15));
        wait_idle("t1");
        check("t1_no_bubble", r_waits, 0);
        check_beats("t1", 16, 32'hA000_0000);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_done_lat", done_cyc - last_hs_cyc, 1);
        check("t1_err", o_err, 0);

        // Downstream backpressure
        start(32'h2000_0000, 18'd8);
        do_ar(0, 32'h2000_0000, 8'd7, hold);
        max_stall_r = 0;
        stall_r = 0;
        rready_low_seen = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) r_beat(32'hB000_0000 + 32'(i), 2'b00, (i == 7));
            end
            begin
                repeat (2) @(posedge clk);
                #1 i_rd_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 i_rd_ready = 1'b1;
            end
        join
        wait_idle("t2");
        check_beats("t2", 8, 32'hB000_0000);
        check("t2_stall_within2", (max_stall_r <= 2), 1);
        check("t2_rready_dropped", rready_low_seen, 1);
        check("t2_done_cnt", done_cnt, 1);

        // ARREADY delayed 5 cycles
        start(32'h3000_0100, 18'd4);
        do_ar(5, 32'h3000_0100, 8'd3, hold);
        check("t3_ar_hold", hold, 6);
        for (int i = 0; i < 4; i++) r_beat(32'hC000_0000 + 32'(i), 2'b00, (i == 3));
        wait_idle("t3");
        check("t3_ar_cnt", ar_cnt, 1);
        check_beats("t3", 4, 32'hC000_0000);

        // Length edge cases
        start(32'h4000_0000, 18'd0);
        @(negedge clk);
        check("t4a_arlen", M_ARLEN, 0);
        check("t4a_err", o_err, 0);
        @(posedge clk); #1;
        do_ar(0, 32'h4000_0000, 8'd0, hold);
        r_beat(32'hD000_0000, 2'b00, 1'b1);
        wait_idle("t4a");
        check_beats("t4a", 1, 32'hD000_0000);
        check("t4a_err_end", o_err, 0);

        start(32'h5000_0000, 18'd20);
        @(negedge clk);
        check("t4b_arlen", M_ARLEN, 15);
        check("t4b_err", o_err, 1);
        @(posedge clk); #1;
        do_ar(0, 32'h5000_0000, 8'd15, hold);
        for (int i = 0; i < 16; i++) r_beat(32'hE000_0000 + 32'(i), 2'b00, (i == 15));
        wait_idle("t4b");
        check_beats("t4b", 16, 32'hE000_0000);

        // SLVERR on beat 3, early RLAST on beat 10
        start(32'h6000_0000, 18'd16);
        @(negedge clk);
        check("t5_err_cleared", o_err, 0);
        @(posedge clk); #1;
        do_ar(0, 32'h6000_0000, 8'd15, hold);
        for (int i = 0; i < 10; i++) r_beat(32'hF000_0000 + 32'(i), (i == 2) ? 2'b10 : 2'b00, (i == 9));
        wait_idle("t5");
        check_beats("t5", 10, 32'hF000_0000);
        check("t5_err", o_err, 1);
        check("t5_done_cnt", done_cnt, 1);

        // Async reset mid-burst, then restart
        start(32'h7000_0000, 18'd16);
        do_ar(0, 32'h7000_0000, 8'd15, hold);
        for (int i = 0; i < 6; i++) r_beat(32'h7700_0000 + 32'(i), 2'b00, 1'b0);
        M_RVALID = 1'b1;
        M_RDATA = 32'h7700_0006;
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("t6_async_rready", M_RREADY, 0);
        check("t6_async_busy", o_busy, 0);
        check("t6_async_rd_valid", o_rd_valid, 0);
        check("t6_async_araddr", M_ARADDR, 0);
        check("t6_async_arsize", M_ARSIZE, 3'd2);
        M_RVALID = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;

        start(32'h8000_0000, 18'd4);
        do_ar(0, 32'h8000_0000, 8'd3, hold);
        i_ctrl_read = 1'b1;
        i_read_addr = 32'hDEAD_0000;
        i_num_trans = 18'd3;
        @(posedge clk); #1;
        i_ctrl_read = 1'b0;
        @(negedge clk);
        check("t6_ignored_err", o_err, 1);
        check("t6_ignored_addr", M_ARADDR, 32'h8000_0000);
        check("t6_ignored_busy", o_busy, 1);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) r_beat(32'h8800_0000 + 32'(i), 2'b00, (i == 3));
        wait_idle("t6");
        check_beats("t6", 4, 32'h8800_0000);
        check("t6_ar_cnt", ar_cnt, 1);
        check("t6_done_cnt", done_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
